// File: rtl/pia_rx_ctrl.sv
// rtl/pia_rx_ctrl.sv - UART receive FIFO presented to the 6502 bus as an Apple-1 PIA keyboard port
//
// Ports:
//   clk, rst          master clock, synchronous active-high reset
//   rx_valid/rx_data  one-cycle byte pulse from the UART receiver
//   rx_error          framing error flag qualifying rx_valid
//   rx_busy           UART is mid-frame
//   bus_strobe        one-cycle CPU access strobe (bus_rw 1=read, bus_reg 0=KBD 1=KBDCR)
//   bus_wdata         CPU write data
//   bus_rdata         registered read data, valid one clk after the strobe
//   cts               flow control to host, high = stop sending
//   overflow          sticky flag, byte dropped because the FIFO was full
//   count             FIFO fill level, 0..DEPTH

module pia_rx_ctrl #(
    parameter int DEPTH      = 16,
    parameter int CTS_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     rx_error,
    input  logic                     rx_busy,
    input  logic                     bus_strobe,
    input  logic                     bus_rw,
    input  logic                     bus_reg,
    input  logic [7:0]               bus_wdata,
    output logic [7:0]               bus_rdata,
    output logic                     cts,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic kbd_rd;
    logic cr_rd;
    logic flush;
    logic nonempty;
    logic full;
    logic push_req;
    logic pop;
    logic push;
    logic ovf_evt;

    // Bit 7 of received data is replaced by the strobe bit on read, and only
    // bit 0 of a KBDCR write has meaning.
    logic unused_bits;
    assign unused_bits = ^{rx_data[7], bus_wdata[7:1]};

    assign kbd_rd   = bus_strobe & bus_rw & ~bus_reg;
    assign cr_rd    = bus_strobe & bus_rw & bus_reg;
    assign flush    = bus_strobe & ~bus_rw & bus_reg & bus_wdata[0];
    assign nonempty = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign push_req = rx_valid & ~rx_error;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted. Flush overrides both and never counts as an overflow.
    assign pop      = kbd_rd & nonempty;
    assign push     = push_req & (~full | pop) & ~flush;
    assign ovf_evt  = push_req & full & ~pop & ~flush;

    assign cts = rx_busy | (count >= CW'(CTS_THRESH));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            bus_rdata <= 8'h00;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rx_data[6:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A fresh overflow beats the clear-on-read of KBDCR.
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (cr_rd) begin
                overflow <= 1'b0;
            end

            if (kbd_rd) begin
                bus_rdata <= nonempty ? {1'b1, mem[rd_ptr]} : 8'h00;
            end else if (cr_rd) begin
                bus_rdata <= {nonempty, overflow, 6'b0};
            end
        end
    end

endmodule

// File: tb/tb_pia_rx_ctrl.sv
// tb/tb_pia_rx_ctrl.sv - directed self-checking bench for pia_rx_ctrl

module tb_pia_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       rx_busy;
    logic       bus_strobe;
    logic       bus_rw;
    logic       bus_reg;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       cts;
    logic       overflow;
    logic [4:0] count;

    int passed = 0;
    int total  = 0;

    pia_rx_ctrl #(.DEPTH(16), .CTS_THRESH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_error   (rx_error),
        .rx_busy    (rx_busy),
        .bus_strobe (bus_strobe),
        .bus_rw     (bus_rw),
        .bus_reg    (bus_reg),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .cts        (cts),
        .overflow   (overflow),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic bus_op(input logic rw, input logic rg, input logic [7:0] wd);
        bus_strobe = 1'b1;
        bus_rw     = rw;
        bus_reg    = rg;
        bus_wdata  = wd;
        tick();
        bus_strobe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        total++; if (cts !== 1'b0) $display("FAIL reset_cts got %b want 0", cts); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
        total++; if (bus_rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", bus_rdata); else passed++;
        bus_op(1'b1, 1'b1, 8'h00);
        total++; if (bus_rdata !== 8'h00) $display("FAIL reset_kbdcr got %h want 00", bus_rdata); else passed++;
        bus_op(1'b1, 1'b0, 8'h00);
        total++; if (bus_rdata !== 8'h00) $display("FAIL reset_kbd got %h want 00", bus_rdata); else passed++;
    endtask

    task automatic test_single();
        push_byte(8'hC1);
        total++; if (count !== 5'd1) $display("FAIL single_count got %0d want 1", count); else passed++;
        bus_op(1'b1, 1'b1, 8'h00);
        total++; if (bus_rdata !== 8'h80) $display("FAIL single_kbdcr got %h want 80", bus_rdata); else passed++;
        bus_op(1'b1, 1'b0, 8'h00);
        total++; if (bus_rdata !== 8'hC1) $display("FAIL single_kbd got %h want c1", bus_rdata); else passed++;
        total++; if (count !== 5'd0) $display("FAIL single_count_after got %0d want 0", count); else passed++;
        bus_op(1'b1, 1'b0, 8'h00);
        total++; if (bus_rdata !== 8'h00) $display("FAIL single_kbd_empty got %h want 00", bus_rdata); else passed++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h30 + 8'(i));
            if (i == 10) begin
                total++; if (cts !== 1'b0) $display("FAIL fill_cts_11 got %b want 0", cts); else passed++;
            end
            if (i == 11) begin
                total++; if (cts !== 1'b1) $display("FAIL fill_cts_12 got %b want 1", cts); else passed++;
            end
        end
        total++; if (count !== 5'd16) $display("FAIL fill_count got %0d want 16", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fill_ovf_pre got %b want 0", overflow); else passed++;
        push_byte(8'h40);
        total++; if (overflow !== 1'b1) $display("FAIL fill_ovf got %b want 1", overflow); else passed++;
        total++; if (count !== 5'd16) $display("FAIL fill_count_ovf got %0d want 16", count); else passed++;
        bus_op(1'b1, 1'b1, 8'h00);
        total++; if (bus_rdata !== 8'hC0) $display("FAIL fill_kbdcr got %h want c0", bus_rdata); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fill_ovf_clr got %b want 0", overflow); else passed++;
        for (int i = 0; i < 16; i++) begin
            bus_op(1'b1, 1'b0, 8'h00);
            total++;
            if (bus_rdata !== (8'hB0 + 8'(i))) $display("FAIL drain_%0d got %h want %h", i, bus_rdata, 8'hB0 + 8'(i));
            else passed++;
        end
        total++; if (count !== 5'd0) $display("FAIL drain_count got %0d want 0", count); else passed++;
        total++; if (cts !== 1'b0) $display("FAIL drain_cts got %b want 0", cts); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'h60;
        bus_op(1'b1, 1'b0, 8'h00);
        rx_valid = 1'b0;
        total++; if (bus_rdata !== 8'hD0) $display("FAIL b2b_full_rd got %h want d0", bus_rdata); else passed++;
        total++; if (count !== 5'd16) $display("FAIL b2b_full_count got %0d want 16", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL b2b_full_ovf got %b want 0", overflow); else passed++;
        for (int i = 0; i < 16; i++) bus_op(1'b1, 1'b0, 8'h00);
        total++; if (bus_rdata !== 8'hE0) $display("FAIL b2b_last got %h want e0", bus_rdata); else passed++;
        rx_valid = 1'b1;
        rx_data  = 8'h2A;
        bus_op(1'b1, 1'b0, 8'h00);
        rx_valid = 1'b0;
        total++; if (bus_rdata !== 8'h00) $display("FAIL b2b_empty_rd got %h want 00", bus_rdata); else passed++;
        total++; if (count !== 5'd1) $display("FAIL b2b_empty_count got %0d want 1", count); else passed++;
        bus_op(1'b1, 1'b0, 8'h00);
        total++; if (bus_rdata !== 8'hAA) $display("FAIL b2b_empty_pushed got %h want aa", bus_rdata); else passed++;
    endtask

    task automatic test_set_wins();
        for (int i = 0; i < 17; i++) push_byte(8'h41);
        rx_valid = 1'b1;
        rx_data  = 8'h42;
        bus_op(1'b1, 1'b1, 8'h00);
        rx_valid = 1'b0;
        total++; if (bus_rdata !== 8'hC0) $display("FAIL setwin_rd got %h want c0", bus_rdata); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL setwin_ovf got %b want 1", overflow); else passed++;
        bus_op(1'b0, 1'b1, 8'h01);
        total++; if (count !== 5'd0) $display("FAIL setwin_flush_count got %0d want 0", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL setwin_flush_ovf got %b want 0", overflow); else passed++;
    endtask

    task automatic test_error_cts();
        push_byte(8'h31);
        rx_error = 1'b1;
        push_byte(8'h32);
        rx_error = 1'b0;
        total++; if (count !== 5'd1) $display("FAIL err_count got %0d want 1", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL err_ovf got %b want 0", overflow); else passed++;
        bus_op(1'b1, 1'b0, 8'h00);
        total++; if (bus_rdata !== 8'hB1) $display("FAIL err_rd got %h want b1", bus_rdata); else passed++;
        rx_busy = 1'b1;
        #1;
        total++; if (cts !== 1'b1) $display("FAIL busy_cts got %b want 1", cts); else passed++;
        rx_busy = 1'b0;
        #1;
        total++; if (cts !== 1'b0) $display("FAIL idle_cts got %b want 0", cts); else passed++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i));
        bus_op(1'b1, 1'b1, 8'h00);
        total++; if (bus_rdata !== 8'h80) $display("FAIL flush_pre_cr got %h want 80", bus_rdata); else passed++;
        bus_op(1'b0, 1'b0, 8'hFF);
        total++; if (bus_rdata !== 8'h80) $display("FAIL kbd_write_hold got %h want 80", bus_rdata); else passed++;
        bus_op(1'b0, 1'b1, 8'hFE);
        total++; if (count !== 5'd5) $display("FAIL noflush_count got %0d want 5", count); else passed++;
        rx_valid = 1'b1;
        rx_data  = 8'h70;
        bus_op(1'b0, 1'b1, 8'h01);
        rx_valid = 1'b0;
        total++; if (count !== 5'd0) $display("FAIL flush_count got %0d want 0", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL flush_ovf got %b want 0", overflow); else passed++;
        bus_op(1'b1, 1'b0, 8'h00);
        total++; if (bus_rdata !== 8'h00) $display("FAIL flush_kbd got %h want 00", bus_rdata); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push_byte(8'h44);
        bus_op(1'b1, 1'b1, 8'h00);
        total++; if (bus_rdata !== 8'h80) $display("FAIL rstmid_pre got %h want 80", bus_rdata); else passed++;
        rst = 1'b1;
        bus_op(1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        total++; if (count !== 5'd0) $display("FAIL rstmid_count got %0d want 0", count); else passed++;
        total++; if (bus_rdata !== 8'h00) $display("FAIL rstmid_rdata got %h want 00", bus_rdata); else passed++;
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        rx_error   = 1'b0;
        rx_busy    = 1'b0;
        bus_strobe = 1'b0;
        bus_rw     = 1'b0;
        bus_reg    = 1'b0;
        bus_wdata  = 8'h00;
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_set_wins();
        test_error_cts();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
